// File: rtl/alu_seq.sv
// rtl/alu_seq.sv - clocked ALU with valid/ready handshake, NZCV flags, shifts and iterative multiply
module alu_seq #(
  parameter  int WIDTH = 32,
  localparam int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       f,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] y,
  output logic             zero,
  output logic             negative,
  output logic             carry,
  output logic             overflow,
  output logic             busy
);

  typedef enum logic {S_IDLE, S_MUL} state_t;

  localparam logic [3:0] OP_AND  = 4'b0000;
  localparam logic [3:0] OP_OR   = 4'b0001;
  localparam logic [3:0] OP_ADD  = 4'b0010;
  localparam logic [3:0] OP_ANDN = 4'b0100;
  localparam logic [3:0] OP_ORN  = 4'b0101;
  localparam logic [3:0] OP_SUB  = 4'b0110;
  localparam logic [3:0] OP_SLT  = 4'b0111;
  localparam logic [3:0] OP_SLL  = 4'b1000;
  localparam logic [3:0] OP_SRL  = 4'b1001;
  localparam logic [3:0] OP_SRA  = 4'b1010;
  localparam logic [3:0] OP_MUL  = 4'b1011;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] y_q, y_d;
  logic             carry_q, carry_d;
  logic             ovf_q, ovf_d;
  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] mcand_q, mcand_d;
  logic [WIDTH-1:0] mplier_q, mplier_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [SHW-1:0]   cnt_q, cnt_d;

  logic             sub_op;
  logic [WIDTH-1:0] b_op;
  logic [WIDTH:0]   sum;
  logic             add_ovf;
  logic [SHW-1:0]   sh;
  logic signed [WIDTH-1:0] a_s;
  logic [WIDTH-1:0] alu_y;
  logic             alu_c;
  logic             alu_v;
  logic             accept;

  assign in_ready  = (state_q == S_IDLE) && (!out_valid_q || out_ready);
  assign accept    = in_valid && in_ready;
  assign busy      = (state_q == S_MUL);
  assign out_valid = out_valid_q;
  assign y         = y_q;
  assign zero      = (y_q == '0);
  assign negative  = y_q[WIDTH-1];
  assign carry     = carry_q;
  assign overflow  = ovf_q;

  // SUB and SLT share the adder as a + ~b + 1
  always_comb begin
    sub_op  = (f == OP_SUB) || (f == OP_SLT);
    b_op    = sub_op ? ~b : b;
    sum     = {1'b0, a} + {1'b0, b_op} + {{WIDTH{1'b0}}, sub_op};
    add_ovf = (a[WIDTH-1] == b_op[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
    sh      = b[SHW-1:0];
    a_s     = $signed(a);
    alu_y   = '0;
    alu_c   = 1'b0;
    alu_v   = 1'b0;
    case (f)
      OP_AND:  alu_y = a & b;
      OP_OR:   alu_y = a | b;
      OP_ADD, OP_SUB: begin
        alu_y = sum[WIDTH-1:0];
        alu_c = sum[WIDTH];
        alu_v = add_ovf;
      end
      OP_ANDN: alu_y = a & ~b;
      OP_ORN:  alu_y = a | ~b;
      OP_SLT:  alu_y = {{(WIDTH-1){1'b0}}, sum[WIDTH-1] ^ add_ovf};
      OP_SLL:  alu_y = a << sh;
      OP_SRL:  alu_y = a >> sh;
      OP_SRA:  alu_y = a_s >>> sh;
      default: alu_y = '0;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    y_d         = y_q;
    carry_d     = carry_q;
    ovf_d       = ovf_q;
    out_valid_d = out_valid_q && !out_ready;
    mcand_d     = mcand_q;
    mplier_d    = mplier_q;
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          if (f == OP_MUL) begin
            mcand_d     = a;
            mplier_d    = b;
            acc_d       = '0;
            cnt_d       = '0;
            out_valid_d = 1'b0;
            state_d     = S_MUL;
          end else begin
            y_d         = alu_y;
            carry_d     = alu_c;
            ovf_d       = alu_v;
            out_valid_d = 1'b1;
          end
        end
      end
      S_MUL: begin
        acc_d    = acc_q + (mplier_q[0] ? mcand_q : '0);
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q + SHW'(1);
        // last iteration publishes the accumulator directly
        if (cnt_q == SHW'(WIDTH - 1)) begin
          y_d         = acc_d;
          carry_d     = 1'b0;
          ovf_d       = 1'b0;
          out_valid_d = 1'b1;
          state_d     = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      y_q         <= '0;
      carry_q     <= 1'b0;
      ovf_q       <= 1'b0;
      out_valid_q <= 1'b0;
      mcand_q     <= '0;
      mplier_q    <= '0;
      acc_q       <= '0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      y_q         <= y_d;
      carry_q     <= carry_d;
      ovf_q       <= ovf_d;
      out_valid_q <= out_valid_d;
      mcand_q     <= mcand_d;
      mplier_q    <= mplier_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
    end
  end

endmodule

// File: tb/tb_alu_seq.sv
// tb/tb_alu_seq.sv - directed-vector bench for alu_seq at WIDTH=32 and WIDTH=8
module tb_alu_seq;

  logic        clk;
  logic        reset;
  logic        in_valid, in_ready, out_valid, out_ready;
  logic [3:0]  f;
  logic [31:0] a, b, y;
  logic        zero, negative, carry, overflow, busy;

  logic        in_valid8, in_ready8, out_valid8, out_ready8;
  logic [3:0]  f8;
  logic [7:0]  a8, b8, y8;
  logic        zero8, negative8, carry8, overflow8, busy8;

  int nchk = 0;
  int nfail = 0;

  alu_seq #(.WIDTH(32)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .f(f), .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready),
    .y(y), .zero(zero), .negative(negative), .carry(carry),
    .overflow(overflow), .busy(busy)
  );

  alu_seq #(.WIDTH(8)) dut8 (
    .clk(clk), .reset(reset), .in_valid(in_valid8), .in_ready(in_ready8),
    .f(f8), .a(a8), .b(b8), .out_valid(out_valid8), .out_ready(out_ready8),
    .y(y8), .zero(zero8), .negative(negative8), .carry(carry8),
    .overflow(overflow8), .busy(busy8)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [3:0] op, input logic [31:0] va, input logic [31:0] vb);
    f = op; a = va; b = vb; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic issue8(input logic [3:0] op, input logic [7:0] va, input logic [7:0] vb);
    f8 = op; a8 = va; b8 = vb; in_valid8 = 1'b1;
    tick();
    in_valid8 = 1'b0;
  endtask

  task automatic drain();
    out_ready = 1'b1; out_ready8 = 1'b1;
    tick();
    out_ready = 1'b0; out_ready8 = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    in_valid = 1'b0; out_ready = 1'b0; f = 4'h0; a = '0; b = '0;
    in_valid8 = 1'b0; out_ready8 = 1'b0; f8 = 4'h0; a8 = '0; b8 = '0;
    tick(); tick();
    reset = 1'b0;
    nchk++; if (out_valid !== 1'b0) begin nfail++; $display("FAIL reset_out_valid got %b exp 0", out_valid); end
    nchk++; if (busy !== 1'b0) begin nfail++; $display("FAIL reset_busy got %b exp 0", busy); end
    nchk++; if (y !== 32'h0) begin nfail++; $display("FAIL reset_y got %h exp 0", y); end
    nchk++; if ({zero, negative, carry, overflow} !== 4'b1000) begin nfail++; $display("FAIL reset_flags got %b exp 1000", {zero, negative, carry, overflow}); end
    nchk++; if (in_ready !== 1'b1) begin nfail++; $display("FAIL reset_in_ready got %b exp 1", in_ready); end
  endtask

  task automatic test_add();
    issue(4'b0010, 32'h7FFF_FFFF, 32'h0000_0001);
    nchk++; if (out_valid !== 1'b1) begin nfail++; $display("FAIL add_latency out_valid got %b exp 1", out_valid); end
    nchk++; if (y !== 32'h8000_0000) begin nfail++; $display("FAIL add_y got %h exp 80000000", y); end
    nchk++; if ({zero, negative, carry, overflow} !== 4'b0101) begin nfail++; $display("FAIL add_flags got %b exp 0101", {zero, negative, carry, overflow}); end
    drain();
    nchk++; if (out_valid !== 1'b0) begin nfail++; $display("FAIL add_transfer out_valid got %b exp 0", out_valid); end
  endtask

  task automatic test_sub_slt();
    issue(4'b0110, 32'h1234_5678, 32'h1234_5678);
    nchk++; if (y !== 32'h0) begin nfail++; $display("FAIL sub_y got %h exp 0", y); end
    nchk++; if ({zero, negative, carry, overflow} !== 4'b1010) begin nfail++; $display("FAIL sub_flags got %b exp 1010", {zero, negative, carry, overflow}); end
    drain();
    issue(4'b0111, 32'hFFFF_FFFF, 32'h0000_0001);
    nchk++; if (y !== 32'h1) begin nfail++; $display("FAIL slt_y got %h exp 1", y); end
    nchk++; if ({carry, overflow} !== 2'b00) begin nfail++; $display("FAIL slt_cv got %b exp 00", {carry, overflow}); end
    drain();
    issue(4'b0111, 32'h0000_0001, 32'hFFFF_FFFF);
    nchk++; if (y !== 32'h0) begin nfail++; $display("FAIL slt_false_y got %h exp 0", y); end
    drain();
  endtask

  task automatic test_shift();
    issue(4'b1010, 32'h8000_0000, 32'hFFFF_FFE4);
    nchk++; if (y !== 32'hF800_0000) begin nfail++; $display("FAIL sra_y got %h exp f8000000", y); end
    drain();
    issue(4'b1001, 32'h8000_0000, 32'hFFFF_FFE4);
    nchk++; if (y !== 32'h0800_0000) begin nfail++; $display("FAIL srl_y got %h exp 08000000", y); end
    drain();
    issue(4'b1000, 32'h0000_1234, 32'h0000_0020);
    nchk++; if (y !== 32'h0000_1234) begin nfail++; $display("FAIL sll_zero_y got %h exp 00001234", y); end
    drain();
    issue(4'b1000, 32'h0000_1234, 32'h0000_0004);
    nchk++; if (y !== 32'h0001_2340) begin nfail++; $display("FAIL sll_y got %h exp 00012340", y); end
    drain();
    issue(4'b1111, 32'hDEAD_BEEF, 32'h1);
    nchk++; if ({y, zero} !== {32'h0, 1'b1}) begin nfail++; $display("FAIL undef_op got %h/%b exp 0/1", y, zero); end
    drain();
  endtask

  task automatic test_mul();
    int n;
    logic rdy_seen;
    issue(4'b1011, 32'h0001_0001, 32'h0001_0001);
    n = 0; rdy_seen = 1'b0;
    while (busy && n < 100) begin
      if (in_ready || out_valid) rdy_seen = 1'b1;
      n++;
      tick();
    end
    nchk++; if (n != 32) begin nfail++; $display("FAIL mul_busy_cycles got %0d exp 32", n); end
    nchk++; if (rdy_seen !== 1'b0) begin nfail++; $display("FAIL mul_in_ready_during_busy got %b exp 0", rdy_seen); end
    nchk++; if (out_valid !== 1'b1) begin nfail++; $display("FAIL mul_out_valid got %b exp 1", out_valid); end
    nchk++; if (y !== 32'h0002_0001) begin nfail++; $display("FAIL mul_y got %h exp 00020001", y); end
    drain();
    issue(4'b1011, 32'hFFFF_FFFF, 32'h0000_0002);
    n = 0;
    while (busy && n < 100) begin n++; tick(); end
    nchk++; if ({out_valid, y} !== {1'b1, 32'hFFFF_FFFE}) begin nfail++; $display("FAIL mul_wrap got %b/%h exp 1/fffffffe", out_valid, y); end
    nchk++; if ({carry, overflow, negative} !== 3'b001) begin nfail++; $display("FAIL mul_flags got %b exp 001", {carry, overflow, negative}); end
    drain();
  endtask

  task automatic test_back_to_back();
    int held;
    int n;
    issue(4'b0010, 32'd3, 32'd4);
    in_valid = 1'b1; f = 4'b0000; a = 32'hFF; b = 32'h0F;
    held = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (y === 32'd7 && out_valid === 1'b1 && in_ready === 1'b0 && zero === 1'b0) held++;
    end
    nchk++; if (held != 10) begin nfail++; $display("FAIL backpressure_hold got %0d exp 10", held); end
    out_ready = 1'b1; f = 4'b0001; a = 32'hF0; b = 32'h0F;
    tick();
    nchk++; if ({out_valid, y} !== {1'b1, 32'hFF}) begin nfail++; $display("FAIL b2b_or got %b/%h exp 1/000000ff", out_valid, y); end
    f = 4'b0110; a = 32'd5; b = 32'd3;
    tick();
    nchk++; if ({out_valid, y, carry} !== {1'b1, 32'd2, 1'b1}) begin nfail++; $display("FAIL b2b_sub got %b/%h/%b exp 1/2/1", out_valid, y, carry); end
    f = 4'b1011; a = 32'd3; b = 32'd5;
    tick();
    in_valid = 1'b0; out_ready = 1'b0;
    nchk++; if ({out_valid, busy} !== 2'b01) begin nfail++; $display("FAIL b2b_mul_accept got %b exp 01", {out_valid, busy}); end
    n = 0;
    while (busy && n < 100) begin n++; tick(); end
    nchk++; if ({out_valid, y} !== {1'b1, 32'd15}) begin nfail++; $display("FAIL b2b_mul got %b/%h exp 1/f", out_valid, y); end
    drain();
  endtask

  task automatic test_reset_mid_mul();
    int seen;
    issue(4'b1011, 32'h1234_5678, 32'h0000_00FF);
    for (int i = 0; i < 10; i++) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    nchk++; if ({out_valid, busy, zero, in_ready} !== 4'b0011) begin nfail++; $display("FAIL mid_mul_reset got %b exp 0011", {out_valid, busy, zero, in_ready}); end
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      if (out_valid) seen++;
      tick();
    end
    nchk++; if (seen != 0) begin nfail++; $display("FAIL mid_mul_no_result got %0d exp 0", seen); end
    issue(4'b0010, 32'd3, 32'd4);
    nchk++; if ({out_valid, y} !== {1'b1, 32'd7}) begin nfail++; $display("FAIL post_reset_add got %b/%h exp 1/7", out_valid, y); end
    drain();
  endtask

  task automatic test_width8();
    int n;
    issue8(4'b0010, 8'hFF, 8'h01);
    nchk++; if ({out_valid8, y8} !== {1'b1, 8'h00}) begin nfail++; $display("FAIL w8_add got %b/%h exp 1/00", out_valid8, y8); end
    nchk++; if ({zero8, negative8, carry8, overflow8} !== 4'b1010) begin nfail++; $display("FAIL w8_add_flags got %b exp 1010", {zero8, negative8, carry8, overflow8}); end
    drain();
    issue8(4'b1011, 8'h10, 8'h10);
    n = 0;
    while (busy8 && n < 100) begin n++; tick(); end
    nchk++; if (n != 8) begin nfail++; $display("FAIL w8_mul_busy_cycles got %0d exp 8", n); end
    nchk++; if ({out_valid8, y8, zero8} !== {1'b1, 8'h00, 1'b1}) begin nfail++; $display("FAIL w8_mul got %b/%h/%b exp 1/00/1", out_valid8, y8, zero8); end
    drain();
  endtask

  initial begin
    test_reset();
    test_add();
    test_sub_slt();
    test_shift();
    test_mul();
    test_back_to_back();
    test_reset_mid_mul();
    test_width8();
    $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
    $finish;
  end

endmodule
